multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB states over a single shared instruction/data memory port with a ready handshake. It generates the timing enables: instruction-register load, PC update, register-file write and memory request. The combinational field decode (ImmSel, ALUSel, ASel, BSel, WBSel) stays in the existing decoder; this block only decides when each enable fires.

## Interface
Parameters:
- MEM_WAIT_MAX, 16: maximum cycles spent in FETCH or MEM waiting for mem_ready before trapping. Legal range is 1..255; the wait counter is 8 bits.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- inst  in  32  instruction register output; stable from the IRWrite edge until the next IRWrite.
- BrEq  in  1  branch comparator: rs1 == rs2.
- BrLT  in  1  branch comparator: rs1 < rs2, signed or unsigned per BrUn.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid only while mem_req = 1.
- IRWrite  out  1  load the instruction register from memory read data.
- PCWrite  out  1  update the PC this cycle.
- PCSel  out  1  PC source: 0 = PC+4, 1 = ALU result.
- RegWEn  out  1  register-file write enable.
- BrUn  out  1  unsigned compare select.
- state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- illegal  out  1  sticky flag: unsupported opcode or branch funct3.
- bus_err  out  1  sticky flag: memory wait timeout.

## Operation
- **Output style.** Outputs are Moore functions of state. The exceptions are IRWrite, the MEM-state PCWrite, and the EXEC branch outputs, which also depend on the current-cycle inputs as listed below.
- **Unlisted outputs.** Any output not named for a state is 0 in that state.
- **FETCH**
  - mem_req = 1, mem_we = 0.
  - IRWrite = mem_ready.
  - On mem_ready, go to DECODE.
- **DECODE** (one cycle). Classify opcode = inst[6:2]:
  - 01100, 00100, 01101, 00101, 11011, 11001, 00000, 01000 → EXEC.
  - 11000 with funct3 in {000, 001, 100, 101, 110, 111} → EXEC.
  - Anything else → TRAP and set illegal.
- **EXEC** (one cycle).
  - Branch (11000):
    - BrUn = inst[13].
    - taken = BrEq for 000, !BrEq for 001, BrLT for 100/110, !BrLT for 101/111.
    - PCWrite = 1, PCSel = taken.
    - Next state: FETCH.
  - Load (00000) or store (01000) → MEM.
  - All other accepted opcodes → WB.
- **MEM**
  - mem_req = 1; mem_we = 1 for store, 0 for load.
  - Load, on mem_ready → WB.
  - Store, on mem_ready → PCWrite = 1 and PCSel = 0 in that same cycle, then FETCH.
- **WB** (one cycle).
  - RegWEn = 1, PCWrite = 1.
  - PCSel = 1 for JAL/JALR, else 0.
  - Next state: FETCH.
- **TRAP**
  - Terminal state; all enables stay 0 until Reset.
  - illegal and bus_err are held.
- **Wait counter**
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle in FETCH/MEM while mem_ready = 0.
  - If mem_ready = 0 on the cycle the counter equals MEM_WAIT_MAX-1: set bus_err, go to TRAP, and drop mem_req on the next cycle.
- **Reset**
  - Takes priority over every transition.
  - In any cycle with Reset high, all outputs are forced to 0, including an in-flight mem_req in MEM.
  - Reset clears illegal, bus_err and the counter.
  - The next state after reset is FETCH.

## Timing
- **Register updates.** All state and flag registers update on the rising edge of Clock.
- **Reset values.** state = FETCH, illegal = 0, bus_err = 0, counter = 0. mem_req is first asserted in the cycle after Reset falls.
- **Latency with zero-wait memory** (mem_ready tied 1), FETCH→FETCH:
  - Branch: 3 cycles.
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- **Handshake.** mem_req stays high and mem_we stays constant until the cycle mem_ready is sampled high. mem_ready while mem_req = 0 is ignored.
- **Enable pulse width.** IRWrite, PCWrite and RegWEn are exactly one cycle per instruction. There is never more than one PCWrite per instruction.
- **Timeout boundary.** mem_ready arriving on the final allowed wait cycle completes normally; no trap.

## Test plan
- **ADD** 0x002081B3, mem_ready = 1, after Reset:
  - state sequence 0, 1, 2, 4, 0.
  - IRWrite in cycle 1; RegWEn = PCWrite = 1 with PCSel = 0 only in cycle 4.
- **LW** 0x0000A103, mem_ready low for 3 cycles in MEM:
  - mem_req = 1 and mem_we = 0 for 4 MEM cycles.
  - then WB with RegWEn = 1; total 8 cycles.
- **Branches:**
  - BEQ 0x00208463 with BrEq = 1 → in EXEC, BrUn = 0, PCWrite = 1, PCSel = 1.
  - BLTU 0x0020E463 with BrLT = 0 → BrUn = 1, PCSel = 0.
  - No RegWEn in either case.
- **SW** 0x0020A023:
  - MEM has mem_we = 1; PCWrite in the mem_ready cycle.
  - RegWEn never asserted; back in FETCH after 4 cycles.
- **Timeout and illegal opcode:**
  - MEM_WAIT_MAX = 16, mem_ready held 0 in FETCH → after 16 cycles state = 7, bus_err = 1, mem_req = 0.
  - Opcode 0x0000007F in DECODE → state = 7, illegal = 1.
- **Reset mid-MEM:**
  - Reset asserted in the 2nd wait cycle of an LW → mem_req = 0 that cycle.
  - state = 0 next cycle; no RegWEn or PCWrite pulse is ever issued for the aborted load.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB over one shared
// memory port and decides when the IR load, PC update, register write and memory
// request enables fire. Field decode (ImmSel, ALUSel, ...) lives in the decoder.
module multicycle_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] inst,
   input  logic        BrEq,
   input  logic        BrLT,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        PCSel,
   output logic        RegWEn,
   output logic        BrUn,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        bus_err
);

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned OP_W    = 5;
   localparam int unsigned F3_W    = 3;

   // Last wait-counter value at which a missing mem_ready still waits no longer.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

   localparam logic [OP_W-1:0] OP_LOAD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_STORE  = 5'b01000;
   localparam logic [OP_W-1:0] OP_BRANCH = 5'b11000;
   localparam logic [OP_W-1:0] OP_JAL    = 5'b11011;
   localparam logic [OP_W-1:0] OP_JALR   = 5'b11001;
   localparam logic [OP_W-1:0] OP_OP     = 5'b01100;
   localparam logic [OP_W-1:0] OP_OPIMM  = 5'b00100;
   localparam logic [OP_W-1:0] OP_LUI    = 5'b01101;
   localparam logic [OP_W-1:0] OP_AUIPC  = 5'b00101;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   logic [OP_W-1:0]  opcode;
   logic [F3_W-1:0]  funct3;
   logic             is_alu;
   logic             is_jump;
   logic             is_load;
   logic             is_store;
   logic             is_branch;
   logic             br_f3_ok;
   logic             op_legal;
   logic             br_cmp;
   logic             br_taken;
   logic             wait_expired;

   // Only opcode and funct3 matter here; the rest of the word belongs to the decoder.
   logic             unused_inst_bits;
   assign unused_inst_bits = ^{inst[31:15], inst[11:7], inst[1:0]};

   assign opcode = inst[6:2];
   assign funct3 = inst[14:12];

   // Opcode classification of the held instruction register.
   always_comb begin
      is_alu    = 1'b0;
      is_jump   = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: is_alu    = 1'b1;
         OP_JAL, OP_JALR:                   is_jump   = 1'b1;
         OP_LOAD:                           is_load   = 1'b1;
         OP_STORE:                          is_store  = 1'b1;
         OP_BRANCH:                         is_branch = 1'b1;
         default:                           ;
      endcase
   end

   // funct3 010/011 are the only unused branch encodings.
   assign br_f3_ok = (funct3[2:1] != 2'b01);
   assign op_legal = is_alu | is_jump | is_load | is_store | (is_branch & br_f3_ok);

   // funct3[2] picks the less-than comparator, funct3[0] inverts the sense.
   assign br_cmp   = funct3[2] ? BrLT : BrEq;
   assign br_taken = br_cmp ^ funct3[0];

   // Memory wait has run out when the last allowed cycle also lacks mem_ready.
   assign wait_expired = (cnt_q == WAIT_LAST) && !mem_ready;

   // State and flag registers.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= S_FETCH;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next-state, wait counter, sticky flags and enable outputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCSel     = 1'b0;
      RegWEn    = 1'b0;
      BrUn      = 1'b0;
      state     = state_q;
      illegal   = illegal_q;
      bus_err   = bus_err_q;

      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            IRWrite = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_expired) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_DECODE: begin
            if (op_legal) begin
               state_d = S_EXEC;
            end else begin
               illegal_d = 1'b1;
               state_d   = S_TRAP;
            end
         end

         S_EXEC: begin
            if (is_branch) begin
               BrUn    = funct3[1];
               PCWrite = 1'b1;
               PCSel   = br_taken;
               state_d = S_FETCH;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store;
            if (mem_ready) begin
               if (is_store) begin
                  PCWrite = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_expired) begin
               bus_err_d = 1'b1;
               state_d   = S_TRAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         S_WB: begin
            RegWEn  = 1'b1;
            PCWrite = 1'b1;
            PCSel   = is_jump;
            state_d = S_FETCH;
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_TRAP;
         end
      endcase

      // Every entry into a memory-waiting state starts a fresh wait count.
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
         cnt_d = '0;
      end

      // Reset silences everything in its own cycle, including an in-flight request.
      if (Reset) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
         IRWrite = 1'b0;
         PCWrite = 1'b0;
         PCSel   = 1'b0;
         RegWEn  = 1'b0;
         BrUn    = 1'b0;
         state   = '0;
         illegal = 1'b0;
         bus_err = 1'b0;
      end
   end

endmodule
